// File: rtl/cache_mem_responder_pkg.sv
// Shared types and constants for the cache memory responder.
package resp_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned ST_W       = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_BURST
  } resp_state_t;

endpackage

// File: rtl/cache_mem_responder_if.sv
// req/rdy memory bus between the cache master and the responder,
// with master-side assumptions and responder-side assertions.
interface cache_mem_responder_if
  import resp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic clk,
  input logic rst
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              rdy;
  logic              valid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, addr, wen, len, wdata, wvalid,
    input  rdy, valid, rdata, err
  );

  modport slave (
    input  req, addr, wen, len, wdata, wvalid,
    output rdy, valid, rdata, err
  );

  // Protocol monitor: tracks an accepted request rise through cycles t+1 and t+2.
  logic              mon_req_q;
  logic              mon_rise_d1;
  logic              mon_rise_d2;
  logic [ADDR_W-1:0] mon_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mon_req_q   <= 1'b0;
      mon_rise_d1 <= 1'b0;
      mon_rise_d2 <= 1'b0;
      mon_addr_q  <= '0;
    end else begin
      mon_req_q   <= req;
      mon_rise_d1 <= req & ~mon_req_q & rdy;
      mon_rise_d2 <= mon_rise_d1;
      mon_addr_q  <= addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      am_req_drop:   assume (!(mon_rise_d2 && req));
      am_addr_hold:  assume (!(req && mon_req_q && (addr != mon_addr_q)));
      as_valid_idle: assert (!(valid && rdy));
      as_setup_busy: assert (!(mon_rise_d1 && (rdy || valid)));
    end
  end

endinterface

// File: rtl/cache_mem_responder_sram.sv
// Single-port synchronous SRAM with registered read data.
module resp_sram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Slave-side memory responder: accepts one req/rdy transaction at a time and
// streams read beats from, or absorbs write beats into, an internal SRAM.
module cache_mem_responder
  import resp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 0
) (
  input logic                  clk,
  input logic                  rst,
  cache_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OFF_W = $clog2(WORD_BYTES);
  localparam int unsigned LAT_W = 4;

  localparam logic [ST_W-1:0] S_IDLE     = ST_W'(ST_IDLE);
  localparam logic [ST_W-1:0] S_SETUP    = ST_W'(ST_SETUP);
  localparam logic [ST_W-1:0] S_RD_WAIT  = ST_W'(ST_RD_WAIT);
  localparam logic [ST_W-1:0] S_RD_BURST = ST_W'(ST_RD_BURST);
  localparam logic [ST_W-1:0] S_WR_BURST = ST_W'(ST_WR_BURST);

  logic [ST_W-1:0]   state, state_n;
  logic              req_q;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic [LAT_W-1:0]  lat_cnt, lat_n;
  logic              wen_q, wen_n;
  logic              rdy_r, rdy_n;
  logic              valid_r, valid_n;
  logic              err_r, err_n;
  logic              issue;
  logic              wr_beat;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] rdata_q;
  logic              req_rise;
  logic              unused_addr_hi;

  assign req_rise       = bus.req & ~req_q;
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+OFF_W];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      lat_cnt <= '0;
      wen_q   <= 1'b0;
      rdy_r   <= 1'b1;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_n;
      req_q   <= bus.req;
      idx     <= idx_n;
      cnt     <= cnt_n;
      lat_cnt <= lat_n;
      wen_q   <= wen_n;
      rdy_r   <= rdy_n;
      valid_r <= valid_n;
      err_r   <= err_n;
    end
  end

  // Next state; a read beat is issued to the SRAM one cycle before it is shown.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    lat_n   = lat_cnt;
    wen_n   = wen_q;
    err_n   = err_r;
    issue   = 1'b0;
    wr_beat = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_rise) begin
          state_n = S_SETUP;
          idx_n   = bus.addr[IDX_W+OFF_W-1:OFF_W];
          cnt_n   = bus.len;
          wen_n   = bus.wen;
          if (bus.addr[OFF_W-1:0] != '0) begin
            err_n = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else if (wen_q) begin
          state_n = S_WR_BURST;
        end else if (RD_LAT == 0) begin
          state_n = S_RD_BURST;
          issue   = 1'b1;
        end else begin
          state_n = S_RD_WAIT;
          lat_n   = LAT_W'(RD_LAT);
        end
      end
      S_RD_WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          state_n = S_RD_BURST;
          issue   = 1'b1;
        end else begin
          lat_n = lat_cnt - LAT_W'(1);
        end
      end
      S_RD_BURST: begin
        if (cnt != '0) begin
          issue = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WR_BURST: begin
        if (bus.wvalid) begin
          wr_beat = 1'b1;
          if (cnt == LEN_W'(1)) begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (issue || wr_beat) begin
      idx_n = idx + IDX_W'(1);
      cnt_n = cnt - LEN_W'(1);
    end
  end

  assign valid_n = issue;
  assign rdy_n   = (state_n == S_IDLE);
  assign mem_re  = issue;
  assign mem_we  = wr_beat & ~rst;

  resp_sram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .re    (mem_re),
    .we    (mem_we),
    .addr  (idx),
    .wdata (bus.wdata),
    .q     (rdata_q)
  );

  assign bus.rdy   = rdy_r;
  assign bus.valid = valid_r;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_r;

endmodule
